// File: rtl/operand_fetch.sv
// operand_fetch: MSP430 addressing-mode sequencer between decode and ALU.
// Build option: OPF_MOV_NO_DST_READ_EN skips the destination read for MOV.
module operand_fetch #(
  parameter int ACK_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  output logic [3:0]  reg_regno,
  output logic [1:0]  reg_As,
  output logic        reg_bytemode,
  output logic        reg_post_inc,
  input  logic [15:0] reg_value,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [15:0] op_instr,
  output logic [15:0] op_src,
  output logic [15:0] op_dst,
  output logic [15:0] op_dst_addr,
  output logic        op_dst_mem,
  output logic        op_err
);

  typedef enum logic [2:0] {
    IDLE, SRC_REG, SRC_EXT, SRC_MEM,
    DST_REG, DST_EXT, DST_MEM, OUT
  } state_t;

  state_t state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] src_q, src_d;
  logic [15:0] dst_q, dst_d;
  logic [15:0] daddr_q, daddr_d;
  logic [15:0] addr_q, addr_d;
  logic        dmem_q, dmem_d;
  logic        err_q, err_d;
  logic        live_q;
  logic [31:0] tcnt_q, tcnt_d;

  logic [3:0]  rs, rd;
  logic [1:0]  as_f, dm;
  logic        bw, fmt2, cg_s, cg_d;
  logic        busy, tmo;
  logic [15:0] mdata, maddr;

  assign rs   = ir_q[11:8];
  assign rd   = ir_q[3:0];
  assign as_f = ir_q[5:4];
  assign bw   = ir_q[6];
  assign fmt2 = ir_q[15:12] == 4'b0001;
  assign dm   = fmt2 ? as_f : {1'b0, ir_q[7]};
  assign cg_s = (rs == 4'd3) || (rs == 4'd2 && as_f[1]);
  assign cg_d = fmt2 && ((rd == 4'd3) || (rd == 4'd2 && as_f[1]));

  assign busy = (state_q == SRC_EXT) || (state_q == SRC_MEM)
             || (state_q == DST_EXT) || (state_q == DST_MEM);
  assign tmo  = (ACK_TIMEOUT > 0) && busy && !mem_ack
             && (tcnt_q == 32'(ACK_TIMEOUT - 1));

  // Byte lanes select on the unaligned address bit
  assign mdata = bw ? {8'h00, addr_q[0] ? mem_rdata[15:8]
                                        : mem_rdata[7:0]}
                    : mem_rdata;
  assign maddr = bw ? addr_q : {addr_q[15:1], 1'b0};

  assign mem_req     = busy;
  assign op_valid    = state_q == OUT;
  assign op_instr    = ir_q;
  assign op_src      = src_q;
  assign op_dst      = dst_q;
  assign op_dst_addr = daddr_q;
  assign op_dst_mem  = dmem_q;
  assign op_err      = err_q;

  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    src_d        = src_q;
    dst_d        = dst_q;
    daddr_d      = daddr_q;
    addr_d       = addr_q;
    dmem_d       = dmem_q;
    err_d        = err_q;
    tcnt_d       = (busy && !mem_ack) ? tcnt_q + 32'd1 : 32'd0;
    instr_ready  = 1'b0;
    reg_regno    = 4'd0;
    reg_As       = 2'd0;
    reg_bytemode = 1'b0;
    reg_post_inc = 1'b0;
    mem_addr     = 16'h0000;
    unique case (state_q)
      IDLE: begin
        instr_ready = live_q;
        if (instr_valid && live_q) begin
          ir_d    = instr;
          src_d   = 16'h0000;
          dst_d   = 16'h0000;
          daddr_d = 16'h0000;
          dmem_d  = 1'b0;
          err_d   = 1'b0;
          unique case (1'b1)
            instr[15:14] != 2'b00:   state_d = SRC_REG;
            instr[15:12] == 4'b0001: state_d = DST_REG;
            default:                 state_d = OUT;
          endcase
        end
      end
      SRC_REG: begin
        reg_regno    = rs;
        reg_As       = as_f;
        reg_bytemode = bw;
        addr_d       = reg_value;
        if (cg_s || as_f == 2'b00) begin
          src_d   = reg_value;
          state_d = DST_REG;
        end else if (as_f == 2'b01) begin
          state_d = SRC_EXT;
        end else begin
          state_d = SRC_MEM;
        end
      end
      SRC_EXT, DST_EXT: begin
        mem_addr = reg_value;
        if (mem_ack) begin
          reg_post_inc = 1'b1;
          addr_d       = mem_rdata + addr_q;
          if (state_q == SRC_EXT) begin
            state_d = SRC_MEM;
          end else begin
            daddr_d = mem_rdata + addr_q;
            dmem_d  = 1'b1;
            state_d = DST_MEM;
`ifdef OPF_MOV_NO_DST_READ_EN
            if (ir_q[15:12] == 4'h4) begin
              dst_d   = 16'h0000;
              state_d = OUT;
            end
`endif
          end
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = OUT;
        end
      end
      SRC_MEM: begin
        reg_regno    = rs;
        reg_As       = as_f;
        reg_bytemode = bw;
        mem_addr     = maddr;
        if (mem_ack) begin
          src_d        = mdata;
          reg_post_inc = as_f == 2'b11;
          state_d      = DST_REG;
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = OUT;
        end
      end
      DST_REG: begin
        reg_regno    = rd;
        reg_As       = dm;
        reg_bytemode = bw;
        addr_d       = reg_value;
        if (cg_d || dm == 2'b00) begin
          dst_d   = reg_value;
          daddr_d = {12'h000, rd};
          dmem_d  = 1'b0;
          state_d = OUT;
        end else if (dm == 2'b01) begin
          state_d = DST_EXT;
        end else begin
          daddr_d = reg_value;
          dmem_d  = 1'b1;
          state_d = DST_MEM;
        end
      end
      DST_MEM: begin
        reg_regno    = rd;
        reg_As       = dm;
        reg_bytemode = bw;
        mem_addr     = maddr;
        if (mem_ack) begin
          dst_d        = mdata;
          reg_post_inc = dm == 2'b11;
          state_d      = OUT;
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = OUT;
        end
      end
      OUT: begin
        if (op_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      ir_q    <= 16'h0000;
      src_q   <= 16'h0000;
      dst_q   <= 16'h0000;
      daddr_q <= 16'h0000;
      addr_q  <= 16'h0000;
      dmem_q  <= 1'b0;
      err_q   <= 1'b0;
      live_q  <= 1'b0;
      tcnt_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      daddr_q <= daddr_d;
      addr_q  <= addr_d;
      dmem_q  <= dmem_d;
      err_q   <= err_d;
      live_q  <= 1'b1;
      tcnt_q  <= tcnt_d;
    end
  end

endmodule
